// File: rtl/booth_datapath_if.sv
// Enable/result interface between the Booth multiplier controller (master) and
// its datapath (slave).
interface booth_datapath_if #(
    parameter int WIDTH = 8
);
    logic                 en_i;
    logic                 en_pp;
    logic                 en_fp;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 count;
    logic [2*WIDTH-1:0]   product;
    logic                 product_valid;
    logic                 err;

    modport master (
        output en_i, en_pp, en_fp, multiplicand, multiplier,
        input  count, product, product_valid, err
    );

    modport slave (
        input  en_i, en_pp, en_fp, multiplicand, multiplier,
        output count, product, product_valid, err
    );
endinterface

// File: rtl/booth_datapath.sv
// Signed radix-2 Booth multiplier datapath: A/Q/q_m1/M/iter registers plus the
// IDLE/RUN/HOLD phase. Optional protocol checker: define BOOTH_PROTO_CHK_EN.
module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    booth_datapath_if.slave  bus
);
    localparam int ITER_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } phase_t;

    phase_t                    r_phase;
    phase_t                    w_phase_next;
    logic signed [WIDTH:0]     r_a;
    logic signed [WIDTH:0]     r_m;
    logic signed [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]          r_q;
    logic                      r_q_m1;
    logic [ITER_W-1:0]         r_iter;
    logic [2*WIDTH-1:0]        r_product;
    logic                      r_product_valid;
    logic                      w_done;
    logic                      w_load;
    logic                      w_final;
    logic                      w_step;

    // Priority en_i > en_fp > en_pp: a lower enable never acts alongside a higher one.
    assign w_done  = (r_iter == ITER_W'(WIDTH));
    assign w_load  = bus.en_i;
    assign w_final = !bus.en_i && bus.en_fp && w_done;
    assign w_step  = !bus.en_i && !bus.en_fp && bus.en_pp && (r_phase == RUN) && !w_done;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_phase_next = r_phase;
        case (r_phase)
            IDLE:    if (w_load) w_phase_next = RUN;
            RUN:     if (w_load) w_phase_next = RUN;
                     else if (w_final) w_phase_next = HOLD;
            HOLD:    if (w_load) w_phase_next = RUN;
            default: w_phase_next = IDLE;
        endcase
    end

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q_m1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
            r_phase <= w_phase_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a             <= '0;
            r_m             <= '0;
            r_q             <= '0;
            r_q_m1          <= 1'b0;
            r_iter          <= '0;
            r_product       <= '0;
            r_product_valid <= 1'b0;
        end else if (w_load) begin
            r_m             <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            r_q             <= bus.multiplier;
            r_a             <= '0;
            r_q_m1          <= 1'b0;
            r_iter          <= '0;
            r_product_valid <= 1'b0;
        end else if (w_final) begin
            r_product       <= {r_a[WIDTH-1:0], r_q};
            r_product_valid <= 1'b1;
        end else if (w_step) begin
            // Arithmetic shift of {A', Q, q_m1}: A's sign bit is replicated.
            r_a    <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q    <= {w_sum[0], r_q[WIDTH-1:1]};
            r_q_m1 <= r_q[0];
            r_iter <= r_iter + ITER_W'(1);
        end
    end

    assign bus.count         = w_done;
    assign bus.product       = r_product;
    assign bus.product_valid = r_product_valid;

`ifdef BOOTH_PROTO_CHK_EN
    logic r_err;
    logic w_violation;

    always_comb begin
        w_violation = ($countones({bus.en_i, bus.en_pp, bus.en_fp}) > 1)
                   || (bus.en_pp && ((r_phase != RUN) || w_done))
                   || (bus.en_fp && !w_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_err <= 1'b0;
        else if (w_violation) r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_booth_datapath.sv
// Directed self-checking bench for booth_datapath (WIDTH=8) with hand-computed products.
module tb_booth_datapath;
    localparam int WIDTH = 8;
`ifdef BOOTH_PROTO_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    booth_datapath_if #(.WIDTH(WIDTH)) bus ();

    booth_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given enables, then enables drop; outputs settle by #1.
    task automatic pulse(input logic i, input logic pp, input logic fp);
        @(negedge clk);
        bus.en_i  = i;
        bus.en_pp = pp;
        bus.en_fp = fp;
        @(posedge clk);
        #1;
        bus.en_i  = 1'b0;
        bus.en_pp = 1'b0;
        bus.en_fp = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        @(negedge clk);
        bus.multiplicand = m;
        bus.multiplier   = q;
        pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.en_i = 1'b0;
        bus.en_pp = 1'b0;
        bus.en_fp = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", bus.count, 0);
        check("reset_product", bus.product, 0);
        check("reset_valid", bus.product_valid, 0);
        check("reset_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;

        // 3 x 5
        load(8'd3, 8'd5);
        check("3x5_count_after_load", bus.count, 0);
        steps(7);
        check("3x5_count_after_7", bus.count, 0);
        steps(1);
        check("3x5_count_after_8", bus.count, 1);
        check("3x5_valid_before_fp", bus.product_valid, 0);
        pulse(1'b0, 1'b0, 1'b1);
        check("3x5_product", bus.product, 32'h000F);
        check("3x5_valid", bus.product_valid, 1);
        check("3x5_err", bus.err, 0);

        // -7 x 6
        load(8'hF9, 8'd6);
        check("m7x6_valid_cleared", bus.product_valid, 0);
        check("m7x6_product_held", bus.product, 32'h000F);
        steps(8);
        pulse(1'b0, 1'b0, 1'b1);
        check("m7x6_product", bus.product, 32'hFFD6);
        check("m7x6_valid", bus.product_valid, 1);

        // -128 x -128: needs the extended A
        load(8'h80, 8'h80);
        steps(8);
        pulse(1'b0, 1'b0, 1'b1);
        check("m128sq_product", bus.product, 32'h4000);
        check("m128sq_err", bus.err, 0);

        // 12 x -3 with three surplus steps before en_fp
        load(8'd12, 8'hFD);
        steps(8);
        check("12xm3_count", bus.count, 1);
        steps(3);
        check("12xm3_count_after_extra", bus.count, 1);
        pulse(1'b0, 1'b0, 1'b1);
        check("12xm3_product", bus.product, 32'hFFDC);
        check("12xm3_err", bus.err, {31'd0, CHK_EN});

        // en_i together with en_pp: load wins, iteration starts from zero
        @(negedge clk);
        bus.multiplicand = 8'd2;
        bus.multiplier   = 8'd2;
        pulse(1'b1, 1'b1, 1'b0);
        check("2x2_count_after_combo", bus.count, 0);
        check("2x2_valid_after_combo", bus.product_valid, 0);
        steps(7);
        check("2x2_count_after_7", bus.count, 0);
        steps(1);
        check("2x2_count_after_8", bus.count, 1);
        pulse(1'b0, 1'b0, 1'b1);
        check("2x2_product", bus.product, 32'h0004);
        check("2x2_err", bus.err, {31'd0, CHK_EN});

        // Early en_fp is ignored; then reset mid-run aborts to zero
        load(8'd5, 8'd7);
        steps(4);
        pulse(1'b0, 1'b0, 1'b1);
        check("early_fp_product", bus.product, 32'h0004);
        check("early_fp_valid", bus.product_valid, 0);
        check("early_fp_err", bus.err, {31'd0, CHK_EN});
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_product", bus.product, 0);
        check("midreset_valid", bus.product_valid, 0);
        check("midreset_count", bus.count, 0);
        check("midreset_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fresh 2 x 3 after reset
        load(8'd2, 8'd3);
        steps(8);
        pulse(1'b0, 1'b0, 1'b1);
        check("2x3_product", bus.product, 32'h0006);
        check("2x3_valid", bus.product_valid, 1);
        check("2x3_err", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_datapath.md
# booth_datapath

Signed Booth radix-2 multiplier datapath, the execution side of the multiplier controller's enable interface. It consumes `en_i`, `en_pp` and `en_fp`, holds the accumulator, multiplier and iteration-counter registers, and returns `count` to the controller. It sits beside the controller inside the multiplier top level and presents the final registered product to the surrounding logic.

## Interface
- `WIDTH`, default 8: operand width in bits, two's complement; legal range is 2 to 32.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `en_i` input 1: load operands and clear the iteration state.
- `en_pp` input 1: perform one Booth partial-product step.
- `en_fp` input 1: capture the final product.
- `multiplicand` input WIDTH: signed M, sampled on every `en_i` cycle.
- `multiplier` input WIDTH: signed Q, sampled on every `en_i` cycle.
- `count` output 1: high when the iteration counter equals WIDTH. Combinational decode of the counter register.
- `product` output 2*WIDTH: signed registered product.
- `product_valid` output 1: high while `product` holds a result for the current operands.
- `err` output 1: sticky protocol-error flag; see Configuration.

## Operation
- Registers:
  - A: WIDTH+1 bits, sign-extended, so the most negative M does not overflow.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - iter: clog2(WIDTH+1) bits.
  - phase FSM: IDLE, RUN, HOLD.
- Enable priority when several are high in one cycle: `en_i` > `en_fp` > `en_pp`. Only the highest-priority enable acts.
- `en_i`: M ← sext(multiplicand); Q ← multiplier; A ← 0; q_m1 ← 0; iter ← 0; `product_valid` ← 0; phase → RUN. Repeated `en_i` cycles are allowed and re-sample the operands, so operands must stay stable across consecutive load cycles.
- `en_pp` with iter < WIDTH:
  - Select on {Q[0], q_m1}: 01 → A+M; 10 → A−M; 00 or 11 → A unchanged. Arithmetic is modulo 2^(WIDTH+1).
  - Arithmetic-shift {A', Q, q_m1} right by one, replicating the sign bit of A'.
  - iter ← iter+1.
- `en_pp` with iter == WIDTH, or while phase is IDLE or HOLD: no register changes.
- `en_fp` with iter == WIDTH: `product` ← {A[WIDTH-1:0], Q}; `product_valid` ← 1; phase → HOLD.
- `en_fp` with iter < WIDTH: no change to `product` or `product_valid`.
- Phase transitions:
  - IDLE → RUN on `en_i`.
  - RUN → HOLD on a valid `en_fp`.
  - HOLD → RUN on `en_i`.
  - HOLD remains HOLD otherwise; no other exits.
- A, Q, q_m1 and M keep their values after `en_fp` until the next `en_i`.

## Timing
- Reset values: A=0, Q=0, q_m1=0, M=0, iter=0, phase=IDLE, `count`=0, `product`=0, `product_valid`=0, `err`=0.
- Reset asserted mid-operation aborts immediately to the reset values. Any partial result is discarded.
- `count` goes low in the cycle after the `en_i` edge. It goes high in the cycle after the WIDTH-th `en_pp` edge.
- Latency from the first `en_i` edge to `product_valid` high is WIDTH+2 cycles: 1 load, WIDTH steps, then 1 `en_fp`.
- `product` and `product_valid` change only on the `en_fp` edge, the `en_i` edge (valid clears), or reset. They never glitch combinationally.
- The controller must see `count` low during the load cycle and high in the cycle in which it issues `en_fp`. Both follow from the register timing above with no extra pipeline stage.

## Configuration
- Macro: `BOOTH_PROTO_CHK_EN`.
- Defined: `err` is set on the edge following any of these, and is cleared only by reset:
  - More than one enable high in the same cycle.
  - `en_pp` while phase is IDLE or HOLD, or while iter == WIDTH.
  - `en_fp` while iter < WIDTH.
  - The enable priority and datapath behaviour are unchanged.
- Undefined: `err` is tied to 0 and no checker logic is built; datapath behaviour is identical.

## Test plan
- WIDTH=8, M=3, Q=5, then 1 `en_i`, 8 `en_pp`, 1 `en_fp` → `count`=1 after the 8th step; `product`=0x000F; `product_valid`=1 at cycle 10; `err`=0.
- M=−7, Q=6, same sequence → `product`=0xFFD6 (−42).
- M=−128, Q=−128, same sequence → `product`=0x4000 (16384), confirming the extended-A overflow case.
- After `count`=1, apply 3 extra `en_pp` and then `en_fp`:
  - Product still correct for M=12, Q=−3: 0xFFDC.
  - `err`=1 with `BOOTH_PROTO_CHK_EN` defined, 0 without.
- `en_i` and `en_pp` high together with M=2, Q=2 → load only: iter=0, A=0, `count`=0; `err`=1 when checking is enabled.
- Assert `reset` after the 4th `en_pp` → all outputs return to 0 immediately. A fresh 2×3 run then yields `product`=0x0006.
